// File: rtl/pc_ctrl.sv
// Fetch-PC controller: owns the fetch PC, resolves branches/jumps in ID, detects
// load-use and branch-operand hazards and keeps saturating stall/flush counters.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        id_valid,
    input  logic [2:0]  id_br_op,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_simm,
    input  logic [25:0] id_jidx,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_dst,
    input  logic        mem_memread,
    input  logic [4:0]  mem_dst,
    output logic [31:0] if_pc,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pc_fault,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_J    = 3'd6,
        BR_JR   = 3'd7
    } brOp_e;

    logic [31:0] pc_q, pc_d;
    logic [15:0] stallCnt_q, stallCnt_d;
    logic [15:0] flushCnt_q, flushCnt_d;
    logic        fault_q, fault_d;

    brOp_e       brOp;
    logic        exHit, memHit, readsRegs;
    logic        loadUse, branchHaz, stall;
    logic        condMet, taken;
    logic [31:0] target;

    assign brOp = brOp_e'(id_br_op);

    // Hazard detection: register 0 is never a real producer, so it never matches.
    always_comb begin
        exHit     = (ex_dst != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));
        memHit    = (mem_dst != 5'd0) &&
                    ((id_use_rs && (id_rs == mem_dst)) || (id_use_rt && (id_rt == mem_dst)));
        readsRegs = (brOp != BR_NONE) && (brOp != BR_J);
        loadUse   = id_valid && ex_memread && exHit;
        branchHaz = id_valid && readsRegs &&
                    ((ex_regwrite && exHit) || (mem_memread && memHit));
        stall     = loadUse || branchHaz;
    end

    // Branch resolution and target selection; only meaningful once operands are ready.
    always_comb begin
        condMet = 1'b0;
        target  = id_pc4 + id_simm;
        unique case (brOp)
            BR_BEQ:  condMet = (id_rs_val == id_rt_val);
            BR_BNE:  condMet = (id_rs_val != id_rt_val);
            BR_BLEZ: condMet = ($signed(id_rs_val) <= 32'sd0);
            BR_BGTZ: condMet = ($signed(id_rs_val) > 32'sd0);
            BR_BLTZ: condMet = id_rs_val[31];
            BR_J: begin
                condMet = 1'b1;
                target  = {id_pc4[31:28], id_jidx, 2'b00};
            end
            BR_JR: begin
                condMet = 1'b1;
                target  = {id_rs_val[31:2], 2'b00};
            end
            default: condMet = 1'b0;
        endcase
        taken = id_valid && !stall && condMet;
    end

    // Pipeline control decode; hold freezes everything, then stall, then redirect.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (hold) begin
            pc_write = 1'b0;
        end else if (stall) begin
            idex_bubble = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = taken;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        fault_d    = fault_q;
        if (pc_write) begin
            pc_d = taken ? target : (pc_q + 32'd4);
        end
        if (!hold && stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
        if (!hold && taken && (flushCnt_q != 16'hFFFF)) begin
            flushCnt_d = flushCnt_q + 16'd1;
        end
        if (!hold && taken && (brOp == BR_JR) && (id_rs_val[1:0] != 2'b00)) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            stallCnt_q <= 16'd0;
            flushCnt_q <= 16'd0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            fault_q    <= fault_d;
        end
    end

    assign if_pc     = pc_q;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;
    assign pc_fault  = fault_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the fetch-PC rules.
module tb_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, hold, id_valid;
    logic [2:0]  id_br_op;
    logic [31:0] id_pc4, id_simm, id_rs_val, id_rt_val;
    logic [25:0] id_jidx;
    logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
    logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_memread;
    logic [31:0] if_pc;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pc_fault;
    logic [15:0] stall_cnt, flush_cnt;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mPc;
    logic [15:0] mStall, mFlush;
    logic        mFault;

    pc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_br_op(id_br_op), .id_pc4(id_pc4), .id_simm(id_simm), .id_jidx(id_jidx),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_dst(ex_dst), .mem_memread(mem_memread),
        .mem_dst(mem_dst), .if_pc(if_pc), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_fault(pc_fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural reference: hazard and branch rules evaluated directly from the inputs.
    function automatic bit refReads(input logic [4:0] d);
        return (d != 5'd0) && ((id_use_rs && id_rs == d) || (id_use_rt && id_rt == d));
    endfunction

    function automatic bit refStall();
        bit needsOperands;
        needsOperands = (id_br_op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7});
        if (!id_valid) return 1'b0;
        if (ex_memread && refReads(ex_dst)) return 1'b1;
        return needsOperands && ((ex_regwrite && refReads(ex_dst)) ||
                                 (mem_memread && refReads(mem_dst)));
    endfunction

    function automatic bit refTaken();
        int signed rsInt;
        rsInt = int'(id_rs_val);
        if (!id_valid || refStall()) return 1'b0;
        case (id_br_op)
            3'd1: return id_rs_val == id_rt_val;
            3'd2: return id_rs_val != id_rt_val;
            3'd3: return rsInt <= 0;
            3'd4: return rsInt > 0;
            3'd5: return rsInt < 0;
            3'd6, 3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refTarget();
        case (id_br_op)
            3'd6: return (id_pc4 & 32'hF000_0000) | ({6'd0, id_jidx} * 4);
            3'd7: return id_rs_val - (id_rs_val % 4);
            default: return id_pc4 + id_simm;
        endcase
    endfunction

    task automatic clearInputs();
        hold = 0; id_valid = 0; id_br_op = 0; id_pc4 = 0; id_simm = 0; id_jidx = 0;
        id_rs_val = 0; id_rt_val = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_regwrite = 0; ex_memread = 0; ex_dst = 0; mem_memread = 0; mem_dst = 0;
    endtask

    // One clock edge: the model commits using the inputs seen just before the edge.
    task automatic advance();
        bit s, t;
        logic [31:0] tg;
        s  = refStall();
        t  = refTaken();
        tg = refTarget();
        @(posedge clk);
        if (reset) begin
            mPc = RESET_PC; mStall = 0; mFlush = 0; mFault = 0;
        end else if (!hold) begin
            if (!s) mPc = t ? tg : mPc + 32'd4;
            if (s && mStall != 16'hFFFF) mStall = mStall + 1;
            if (t && mFlush != 16'hFFFF) mFlush = mFlush + 1;
            if (t && id_br_op == 3'd7 && id_rs_val[1:0] != 2'b00) mFault = 1'b1;
        end
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1;
        advance();
        advance();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        doReset();
        compared++;
        if (if_pc !== RESET_PC) begin
            mismatched++; $display("[TB] FAIL reset_pc: got %h want %h", if_pc, RESET_PC);
        end
        compared++;
        if ({stall_cnt, flush_cnt, pc_fault} !== 33'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got stall=%h flush=%h fault=%b want zeros",
                     stall_cnt, flush_cnt, pc_fault);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] want;
        doReset();
        for (int i = 1; i <= 3; i++) begin
            compared++;
            if (pc_write !== 1'b1 || ifid_flush !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL free_ctl: got pw=%b fl=%b want 1/0", pc_write, ifid_flush);
            end
            advance();
            want = RESET_PC + 32'(4 * i);
            compared++;
            if (if_pc !== want) begin
                mismatched++; $display("[TB] FAIL free_pc: got %h want %h", if_pc, want);
            end
        end
        compared++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL free_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_beq();
        doReset();
        id_valid = 1; id_br_op = 3'd1; id_rs = 2; id_rt = 3; id_use_rs = 1; id_use_rt = 1;
        id_rs_val = 5; id_rt_val = 5; id_pc4 = 32'h0040_0010; id_simm = 32'hFFFF_FFF0;
        #1;
        compared++;
        if (ifid_flush !== 1'b1 || pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL beq_ctl: got fl=%b pw=%b bub=%b want 1/1/0",
                     ifid_flush, pc_write, idex_bubble);
        end
        advance();
        clearInputs();
        compared++;
        if (if_pc !== 32'h0040_0000 || flush_cnt !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL beq_pc: got pc=%h fc=%h want 00400000/1", if_pc, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        doReset();
        id_valid = 1; id_rs = 8; id_use_rs = 1; ex_memread = 1; ex_regwrite = 1; ex_dst = 8;
        #1;
        compared++;
        if (pc_write !== 1'b0 || idex_bubble !== 1'b1 || ifid_write !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lu_stall: got pw=%b bub=%b iw=%b want 0/1/0",
                     pc_write, idex_bubble, ifid_write);
        end
        advance();
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0; mem_memread = 1; mem_dst = 8;
        #1;
        compared++;
        if (stall_cnt !== 16'd1 || if_pc !== RESET_PC || pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lu_resume: got sc=%h pc=%h pw=%b bub=%b want 1/00400000/1/0",
                     stall_cnt, if_pc, pc_write, idex_bubble);
        end
        advance();
        compared++;
        if (if_pc !== 32'h0040_0004) begin
            mismatched++; $display("[TB] FAIL lu_pc: got %h want 00400004", if_pc);
        end
    endtask

    task automatic test_load_branch();
        doReset();
        id_valid = 1; id_br_op = 3'd2; id_rt = 9; id_use_rt = 1; id_rs_val = 1; id_rt_val = 2;
        id_pc4 = 32'h0040_0004; id_simm = 32'h0000_0020;
        ex_memread = 1; ex_regwrite = 1; ex_dst = 9;
        #1;
        compared++;
        if (idex_bubble !== 1'b1 || pc_write !== 1'b0) begin
            mismatched++; $display("[TB] FAIL lb_stall1: got bub=%b pw=%b want 1/0", idex_bubble, pc_write);
        end
        advance();
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0; mem_memread = 1; mem_dst = 9;
        #1;
        compared++;
        if (idex_bubble !== 1'b1 || pc_write !== 1'b0) begin
            mismatched++; $display("[TB] FAIL lb_stall2: got bub=%b pw=%b want 1/0", idex_bubble, pc_write);
        end
        advance();
        mem_memread = 0; mem_dst = 0;
        #1;
        compared++;
        if (ifid_flush !== 1'b1 || idex_bubble !== 1'b0) begin
            mismatched++; $display("[TB] FAIL lb_resolve: got fl=%b bub=%b want 1/0", ifid_flush, idex_bubble);
        end
        advance();
        clearInputs();
        compared++;
        if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1 || if_pc !== 32'h0040_0024) begin
            mismatched++;
            $display("[TB] FAIL lb_state: got sc=%h fc=%h pc=%h want 2/1/00400024",
                     stall_cnt, flush_cnt, if_pc);
        end
    endtask

    task automatic test_jumps();
        doReset();
        id_valid = 1; id_br_op = 3'd7; id_rs = 3; id_use_rs = 1; id_rs_val = 32'h0040_0102;
        #1;
        compared++;
        if (ifid_flush !== 1'b1) begin
            mismatched++; $display("[TB] FAIL jr_flush: got %b want 1", ifid_flush);
        end
        advance();
        clearInputs();
        compared++;
        if (if_pc !== 32'h0040_0100 || pc_fault !== 1'b1) begin
            mismatched++; $display("[TB] FAIL jr_pc: got pc=%h fault=%b want 00400100/1", if_pc, pc_fault);
        end
        advance();
        advance();
        compared++;
        if (pc_fault !== 1'b1 || if_pc !== 32'h0040_0108) begin
            mismatched++; $display("[TB] FAIL jr_sticky: got fault=%b pc=%h want 1/00400108", pc_fault, if_pc);
        end
        id_valid = 1; id_br_op = 3'd6; id_pc4 = 32'hA000_0004; id_jidx = 26'h000_0010;
        advance();
        clearInputs();
        compared++;
        if (if_pc !== 32'hA000_0040) begin
            mismatched++; $display("[TB] FAIL j_pc: got %h want a0000040", if_pc);
        end
        doReset();
        compared++;
        if (pc_fault !== 1'b0) begin
            mismatched++; $display("[TB] FAIL fault_clear: got %b want 0", pc_fault);
        end
    endtask

    task automatic test_hold();
        doReset();
        advance();
        id_valid = 1; id_rs = 4; id_use_rs = 1; ex_memread = 1; ex_dst = 4; hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b0000) begin
                mismatched++;
                $display("[TB] FAIL hold_ctl: got %b%b%b%b want 0000",
                         pc_write, ifid_write, ifid_flush, idex_bubble);
            end
            advance();
            compared++;
            if (if_pc !== 32'h0040_0004 || stall_cnt !== 16'd0) begin
                mismatched++;
                $display("[TB] FAIL hold_freeze: got pc=%h sc=%h want 00400004/0", if_pc, stall_cnt);
            end
        end
        hold = 0;
        #1;
        compared++;
        if (idex_bubble !== 1'b1) begin
            mismatched++; $display("[TB] FAIL hold_resume: got bub=%b want 1", idex_bubble);
        end
        advance();
        compared++;
        if (stall_cnt !== 16'd1 || if_pc !== 32'h0040_0004) begin
            mismatched++; $display("[TB] FAIL hold_after: got sc=%h pc=%h want 1/00400004", stall_cnt, if_pc);
        end
    endtask

    task automatic test_saturation();
        doReset();
        id_valid = 1; id_rt = 6; id_use_rt = 1; ex_memread = 1; ex_dst = 6;
        repeat (65535) advance();
        compared++;
        if (stall_cnt !== 16'hFFFF) begin
            mismatched++; $display("[TB] FAIL sat_reach: got %h want ffff", stall_cnt);
        end
        advance();
        advance();
        compared++;
        if (stall_cnt !== 16'hFFFF || idex_bubble !== 1'b1) begin
            mismatched++; $display("[TB] FAIL sat_hold: got sc=%h bub=%b want ffff/1", stall_cnt, idex_bubble);
        end
    endtask

    task automatic test_reset_hold();
        clearInputs();
        advance();
        advance();
        id_valid = 1; id_br_op = 3'd6; id_pc4 = 32'h1000_0000; id_jidx = 26'h3;
        hold = 1; reset = 1;
        advance();
        compared++;
        if (if_pc !== RESET_PC || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got pc=%h sc=%h fc=%h want 00400000/0/0",
                     if_pc, stall_cnt, flush_cnt);
        end
        hold = 0;
        advance();
        compared++;
        if (if_pc !== RESET_PC || flush_cnt !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_redirect: got pc=%h fc=%h want 00400000/0", if_pc, flush_cnt);
        end
        reset = 0;
        clearInputs();
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        bit eS, eT;
        doReset();
        for (int n = 0; n < 400; n++) begin
            pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = $urandom;
            reset       = ($urandom_range(0, 49) == 0);
            hold        = ($urandom_range(0, 7) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_br_op    = 3'($urandom_range(0, 7));
            id_pc4      = $urandom;
            id_simm     = $urandom;
            id_jidx     = 26'($urandom);
            id_rs_val   = pool[$urandom_range(0, 3)];
            id_rt_val   = pool[$urandom_range(0, 3)];
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom);
            id_use_rt   = 1'($urandom);
            ex_regwrite = 1'($urandom);
            ex_memread  = ($urandom_range(0, 3) == 0);
            ex_dst      = 5'($urandom_range(0, 3));
            mem_memread = ($urandom_range(0, 3) == 0);
            mem_dst     = 5'($urandom_range(0, 3));
            #1;
            eS = refStall();
            eT = refTaken();
            if (!reset) begin
                compared++;
                if (pc_write !== (!hold && !eS) || ifid_write !== (!hold && !eS) ||
                    ifid_flush !== (!hold && eT) || idex_bubble !== (!hold && eS)) begin
                    mismatched++;
                    $display("[TB] FAIL rnd_ctl: got pw=%b iw=%b fl=%b bub=%b want %b/%b/%b/%b",
                             pc_write, ifid_write, ifid_flush, idex_bubble,
                             !hold && !eS, !hold && !eS, !hold && eT, !hold && eS);
                end
            end
            advance();
            compared++;
            if (if_pc !== mPc || stall_cnt !== mStall || flush_cnt !== mFlush || pc_fault !== mFault) begin
                mismatched++;
                $display("[TB] FAIL rnd_state: got pc=%h sc=%h fc=%h f=%b want %h/%h/%h/%b",
                         if_pc, stall_cnt, flush_cnt, pc_fault, mPc, mStall, mFlush, mFault);
            end
        end
        reset = 0;
        clearInputs();
    endtask

    initial begin
        reset = 1;
        clearInputs();
        mPc = RESET_PC; mStall = 0; mFlush = 0; mFault = 0;
        test_reset();
        test_free_run();
        test_beq();
        test_load_use();
        test_load_branch();
        test_jumps();
        test_hold();
        test_saturation();
        test_reset_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got no completion want finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-PC controller for the five-stage pipeline. Owns the PC register and resolves branches and jumps in ID, using the shifted sign-extended offset from the immediate extender. Detects load-use and branch-operand hazards and drives the stall, flush and bubble controls for the IF/ID and ID/EX registers. Keeps saturating stall and flush counters for performance monitoring.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- hold  in  1  global freeze (memory wait); overrides all other inputs.
- id_valid  in  1  ID holds a real instruction.
- id_br_op  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 j/jal, 111 jr/jalr.
- id_pc4  in  32  PC+4 of the ID instruction.
- id_simm  in  32  sign-extended offset, already shifted left by 2.
- id_jidx  in  26  jump index field.
- id_rs_val, id_rt_val  in  32  forwarded source operands.
- id_rs, id_rt  in  5  source register numbers.
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt.
- ex_regwrite, ex_memread  in  1  EX-stage write and load flags.
- ex_dst  in  5  EX-stage destination register.
- mem_memread  in  1  MEM-stage load flag.
- mem_dst  in  5  MEM-stage destination register.
- if_pc  out  32  current fetch PC (registered).
- pc_write, ifid_write  out  1  enables for the PC and IF/ID registers.
- ifid_flush  out  1  squash the instruction currently in IF.
- idex_bubble  out  1  insert a NOP into ID/EX.
- pc_fault  out  1  sticky flag: jr target was misaligned.
- stall_cnt, flush_cnt  out  16  saturating event counters.

## Operation
- Every hazard check below requires id_valid=1. A destination of register 0 never causes a hazard.
- A source is live when its use bit is set and its register number equals the destination.
- Load-use hazard: ex_memread=1 and ex_dst matches a live source.
- Branch hazard: id_br_op is 001–101 or 111, and either:
  - ex_regwrite=1 and ex_dst matches a live source, or
  - mem_memread=1 and mem_dst matches a live source.
- stall = load-use hazard OR branch hazard.
- Taken conditions, evaluated only when stall=0 and id_valid=1:
  - beq: rs==rt.
  - bne: rs!=rt.
  - blez: rs signed ≤ 0.
  - bgtz: rs signed > 0.
  - bltz: rs signed < 0.
  - j and jr: always taken.
- Branch targets:
  - Conditional branches: id_pc4 + id_simm, modulo 2^32 (wraps, no overflow flag).
  - j: {id_pc4[31:28], id_jidx, 2'b00}.
  - jr: {id_rs_val[31:2], 2'b00}. If id_rs_val[1:0] != 0, pc_fault sets (sticky until reset).
- No delay slot: a taken branch or jump squashes the IF instruction.
- Output decode (combinational), in priority order:
  - hold=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
  - stall=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
  - otherwise: pc_write=1, ifid_write=1, flush=0, bubble=0.
- PC update when pc_write=1: if_pc ← taken ? target : if_pc+4 (wraps at 2^32).
- Counters:
  - stall_cnt +1 on each cycle with stall=1 and hold=0.
  - flush_cnt +1 on each cycle with taken=1 and hold=0.
  - Both saturate at 16'hFFFF.

## Timing
- Reset (synchronous): if_pc=RESET_PC, pc_fault=0, stall_cnt=0, flush_cnt=0.
  - Control outputs are combinational during reset; the bench ignores them while reset=1.
- Decision latency is 0 cycles: control outputs are valid in the same cycle as the ID inputs.
- The new PC is visible on if_pc one edge later.
- Load-use stall lasts exactly 1 cycle, since the load moves on to MEM.
- Branch stall on an ALU producer in EX: 1 cycle.
- Branch stall on a load in EX: 2 cycles (the load-use condition in cycle 1, then the MEM-load condition in cycle 2).
- hold for N cycles freezes if_pc, both counters and pc_fault for N cycles. Decisions resume unchanged after hold drops.
- reset and hold asserted together: reset wins.
- Reset asserted mid-stall or mid-redirect: the pending redirect is discarded and if_pc=RESET_PC.

## Test plan
- Reset, then 3 free cycles with id_valid=0 → if_pc sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; counters 0.
- beq with rs=rt=5, id_pc4=0x00400010, id_simm=0xFFFFFFF0 → ifid_flush=1; next if_pc=0x00400000; flush_cnt=1.
- lw in EX with ex_dst=8, ID add reading rs=8 → one cycle of pc_write=0, idex_bubble=1; stall_cnt=1; normal flow on the next cycle.
- lw in EX with ex_dst=9, ID bne reading rt=9 → 2 stall cycles (stall_cnt=2), then bne resolves.
- jr with rs_val=0x00400102 → if_pc=0x00400100 and pc_fault=1, staying set until reset. j with id_pc4=0xA0000004, jidx=0x0000010 → if_pc=0xA0000040.
- hold=1 for 3 cycles during a stall; preload stall_cnt=0xFFFF and stall again → counter frozen during hold and stays at 0xFFFF at saturation. Reset asserted with hold=1 → if_pc=RESET_PC.
